// File: rtl/nios_sys_pio_pkg.sv
// nios_sys_pio_pkg: register map and edge-type encodings for the PIO capture slave
package nios_sys_pio_pkg;
  localparam logic [1:0] ADDR_DATA    = 2'd0;
  localparam logic [1:0] ADDR_IRQMASK = 2'd2;
  localparam logic [1:0] ADDR_EDGECAP = 2'd3;
  localparam int EDGE_RISE = 0;
  localparam int EDGE_FALL = 1;
  localparam int EDGE_ANY  = 2;
endpackage

// File: rtl/nios_sys_bit_sync.sv
// nios_sys_bit_sync: per-bit flop-chain synchroniser, async active-low reset to 0
module nios_sys_bit_sync #(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  logic [STAGES*WIDTH-1:0] chain;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) chain <= '0;
    else chain <= {chain[(STAGES-1)*WIDTH-1:0], d};
  assign q = chain[STAGES*WIDTH-1 -: WIDTH];
endmodule

// File: rtl/nios_sys_pio_capture.sv
// nios_sys_pio_capture: Avalon-MM input PIO with synchronised edge capture and maskable irq
module nios_sys_pio_capture
  import nios_sys_pio_pkg::*;
#(
  parameter int DATA_WIDTH  = 8,
  parameter int EDGE_TYPE   = 0,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [1:0]            address,
  input  logic                  chipselect,
  input  logic                  write_n,
  input  logic [31:0]           writedata,
  input  logic [DATA_WIDTH-1:0] in_port,
  output logic [31:0]           readdata,
  output logic                  irq
);
  logic [DATA_WIDTH-1:0] sync, prev, edge_det, cap, mask, clr, rd;
  logic wr, unused_wd;
  nios_sys_bit_sync #(.WIDTH(DATA_WIDTH), .STAGES(SYNC_STAGES)) u_sync (
    .clk(clk), .reset_n(reset_n), .d(in_port), .q(sync)
  );
  always_comb begin
    edge_det = EDGE_TYPE == EDGE_FALL ? ~sync & prev :
               EDGE_TYPE == EDGE_ANY  ? sync ^ prev : sync & ~prev;
    wr = chipselect && !write_n;
    clr = (wr && address == ADDR_EDGECAP) ? writedata[DATA_WIDTH-1:0] : '0;
    rd = address == ADDR_DATA    ? sync :
         address == ADDR_IRQMASK ? mask :
         address == ADDR_EDGECAP ? cap  : '0;
  end
  // new edges take priority over a same-cycle write-1-to-clear
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      prev <= '0;
      cap <= '0;
      mask <= '0;
      readdata <= '0;
    end else begin
      prev <= sync;
      cap <= (cap & ~clr) | edge_det;
      if (wr && address == ADDR_IRQMASK) mask <= writedata[DATA_WIDTH-1:0];
      readdata <= 32'(rd);
    end
  assign irq = |(cap & mask);
  assign unused_wd = ^writedata;
endmodule
